// File: rtl/seg_scan_pwm_ctrl.sv
// Multiplexed seven-segment scanner: per-digit time slots with a blanking gap,
// 16-step PWM brightness in the drive window, and frame-based digit blinking.
module seg_scan_pwm_ctrl #(
    parameter int N_DIG     = 8,
    parameter int DWELL     = 1024,
    parameter int BLANK     = 16,
    parameter int BLINK_DIV = 64
) (
    input  logic                 iCLK,
    input  logic                 nRST,
    input  logic                 iEN,
    input  logic [8*N_DIG-1:0]   iSEG,
    input  logic [N_DIG-1:0]     iBLINK,
    input  logic [3:0]           iBRIGHT,
    output logic [N_DIG-1:0]     oS_COM,
    output logic [7:0]           oS_ENS,
    output logic                 oFRAME
);

    localparam int SLOT_W = $clog2(DWELL);
    localparam int DIG_W  = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int FRM_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(DWELL - 1);
    localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK - 1);
    localparam logic [DIG_W-1:0]  DIG_LAST   = DIG_W'(N_DIG - 1);
    localparam logic [FRM_W-1:0]  FRM_LAST   = FRM_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_DRIVE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SLOT_W-1:0]   r_slot;
    logic [DIG_W-1:0]    r_dig;
    logic [3:0]          r_pwm;
    logic [FRM_W-1:0]    r_frm;
    logic                r_blink;
    logic [7:0]          r_shadow;

    logic                w_slot_end;
    logic                w_frame_wrap;
    logic [7:0]          w_seg_cur;
    logic                w_blink_cur;
    logic                w_drive_on;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (iEN) w_state_nxt = S_BLANK;
            S_BLANK: begin
                if (!iEN)                     w_state_nxt = S_IDLE;
                else if (r_slot == BLANK_LAST) w_state_nxt = S_DRIVE;
            end
            S_DRIVE: begin
                if (!iEN)                     w_state_nxt = S_IDLE;
                else if (r_slot == SLOT_LAST) w_state_nxt = S_BLANK;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Select the current digit's pattern and blink bit without a variable part-select.
    always_comb begin
        w_seg_cur   = '0;
        w_blink_cur = 1'b0;
        for (int k = 0; k < N_DIG; k++) begin
            if (r_dig == DIG_W'(k)) begin
                w_seg_cur   = iSEG[8*k +: 8];
                w_blink_cur = iBLINK[k];
            end
        end
    end

    assign w_slot_end   = (r_state != S_IDLE) && (r_slot == SLOT_LAST);
    assign w_frame_wrap = w_slot_end && (r_dig == DIG_LAST);
    assign w_drive_on   = iEN && (r_state == S_DRIVE) && (r_pwm <= iBRIGHT)
                          && !(r_blink && w_blink_cur);

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge iCLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge iCLK or negedge nRST) begin
        if (!nRST) begin
            r_slot   <= '0;
            r_dig    <= '0;
            r_pwm    <= '0;
            r_frm    <= '0;
            r_blink  <= 1'b0;
            r_shadow <= '0;
        end else if (!iEN || r_state == S_IDLE) begin
            r_slot  <= '0;
            r_dig   <= '0;
            r_pwm   <= '0;
            r_frm   <= '0;
            r_blink <= 1'b0;
        end else begin
            r_slot <= w_slot_end ? '0 : r_slot + SLOT_W'(1);
            if (w_slot_end) begin
                r_dig <= (r_dig == DIG_LAST) ? '0 : r_dig + DIG_W'(1);
            end
            // PWM phase restarts in every blank gap so each drive window begins at phase 0.
            r_pwm <= (r_state == S_DRIVE) ? r_pwm + 4'd1 : 4'd0;
            if (w_frame_wrap) begin
                if (r_frm == FRM_LAST) begin
                    r_frm   <= '0;
                    r_blink <= ~r_blink;
                end else begin
                    r_frm <= r_frm + FRM_W'(1);
                end
            end
            if (r_state == S_BLANK && r_slot == '0) begin
                r_shadow <= w_seg_cur;
            end
        end
    end

    always_ff @(posedge iCLK or negedge nRST) begin
        if (!nRST) begin
            oS_COM <= '1;
            oS_ENS <= '0;
            oFRAME <= 1'b0;
        end else begin
            oFRAME <= iEN && (r_state == S_BLANK) && (r_slot == '0) && (r_dig == '0);
            if (w_drive_on) begin
                oS_COM <= ~(N_DIG'(1) << r_dig);
                oS_ENS <= r_shadow;
            end else begin
                oS_COM <= '1;
                oS_ENS <= '0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_pwm_ctrl.sv
// Bench for seg_scan_pwm_ctrl: directed tables, multi-cycle corner sequences and
// randomized traffic compared against an arithmetic cycle-count model.
module tb_seg_scan_pwm_ctrl;

    localparam int N_DIG     = 4;
    localparam int DWELL     = 8;
    localparam int BLANK     = 2;
    localparam int BLINK_DIV = 2;
    localparam int FRAME_LEN = DWELL * N_DIG;

    logic                iCLK = 1'b0;
    logic                nRST;
    logic                iEN;
    logic [8*N_DIG-1:0]  iSEG;
    logic [N_DIG-1:0]    iBLINK;
    logic [3:0]          iBRIGHT;
    logic [N_DIG-1:0]    oS_COM;
    logic [7:0]          oS_ENS;
    logic                oFRAME;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: cycles elapsed since the scan (re)started.
    bit       m_active = 1'b0;
    int       m_c      = 0;
    logic [7:0] m_shadow = '0;

    seg_scan_pwm_ctrl #(
        .N_DIG    (N_DIG),
        .DWELL    (DWELL),
        .BLANK    (BLANK),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .iCLK   (iCLK),
        .nRST   (nRST),
        .iEN    (iEN),
        .iSEG   (iSEG),
        .iBLINK (iBLINK),
        .iBRIGHT(iBRIGHT),
        .oS_COM (oS_COM),
        .oS_ENS (oS_ENS),
        .oFRAME (oFRAME)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: predict the post-edge outputs from the model, advance, then compare.
    task automatic tick();
        logic [N_DIG-1:0] e_com;
        logic [7:0]       e_ens;
        logic             e_frm;
        int slot, dig, frm, ph;
        bit blink;
        e_com = '1;
        e_ens = '0;
        e_frm = 1'b0;
        if (!nRST) begin
            m_active = 1'b0;
            m_c      = 0;
            m_shadow = '0;
        end else begin
            slot  = m_c % DWELL;
            dig   = (m_c / DWELL) % N_DIG;
            frm   = m_c / FRAME_LEN;
            blink = ((frm / BLINK_DIV) % 2) == 1;
            ph    = (slot - BLANK) % 16;
            if (m_active && iEN) begin
                e_frm = (m_c % FRAME_LEN) == 0;
                if (slot >= BLANK && ph <= int'(iBRIGHT) && !(blink && iBLINK[dig])) begin
                    e_com = ~(N_DIG'(1) << dig);
                    e_ens = m_shadow;
                end
            end
            if (m_active && slot == 0) m_shadow = iSEG[8*dig +: 8];
            if (!iEN) begin
                m_active = 1'b0;
                m_c      = 0;
            end else if (!m_active) begin
                m_active = 1'b1;
                m_c      = 0;
            end else begin
                m_c++;
            end
        end
        @(posedge iCLK);
        #1;
        check("com", 32'(oS_COM), 32'(e_com));
        check("ens", 32'(oS_ENS), 32'(e_ens));
        check("frame", 32'(oFRAME), 32'(e_frm));
        check("com_onehot", 32'($countones(~oS_COM) <= 1), 32'd1);
    endtask

    // Restart the scan: one cycle with enable low, then the enable-sampling edge.
    task automatic restart();
        iEN = 1'b0;
        tick();
        iEN = 1'b1;
        tick();
    endtask

    typedef struct {
        int                k;
        logic [N_DIG-1:0]  com;
        logic [7:0]        ens;
        logic              frm;
    } vec_t;

    vec_t tbl[13];
    int   cnt[6];
    int   drv;
    int   ti;

    initial begin
        tbl[0]  = '{1,  4'b1111, 8'h00, 1'b1};
        tbl[1]  = '{2,  4'b1111, 8'h00, 1'b0};
        tbl[2]  = '{3,  4'b1110, 8'h4F, 1'b0};
        tbl[3]  = '{8,  4'b1110, 8'h4F, 1'b0};
        tbl[4]  = '{9,  4'b1111, 8'h00, 1'b0};
        tbl[5]  = '{10, 4'b1111, 8'h00, 1'b0};
        tbl[6]  = '{11, 4'b1101, 8'h5B, 1'b0};
        tbl[7]  = '{16, 4'b1101, 8'h5B, 1'b0};
        tbl[8]  = '{19, 4'b1011, 8'h06, 1'b0};
        tbl[9]  = '{27, 4'b0111, 8'h3F, 1'b0};
        tbl[10] = '{32, 4'b0111, 8'h3F, 1'b0};
        tbl[11] = '{33, 4'b1111, 8'h00, 1'b1};
        tbl[12] = '{35, 4'b1110, 8'h4F, 1'b0};

        nRST    = 1'b0;
        iEN     = 1'b0;
        iSEG    = 32'h3F065B4F;
        iBLINK  = '0;
        iBRIGHT = 4'd15;

        #12;
        check("rst_com", 32'(oS_COM), 32'hF);
        check("rst_ens", 32'(oS_ENS), 32'h0);
        check("rst_frame", 32'(oFRAME), 32'h0);

        // Basic scan order and timing from the enable edge.
        @(posedge iCLK);
        #1;
        nRST = 1'b1;
        iEN  = 1'b1;
        tick();
        ti = 0;
        for (int k = 1; k <= 35; k++) begin
            tick();
            if (ti < 13 && tbl[ti].k == k) begin
                check($sformatf("tbl%0d_com", k), 32'(oS_COM), 32'(tbl[ti].com));
                check($sformatf("tbl%0d_ens", k), 32'(oS_ENS), 32'(tbl[ti].ens));
                check($sformatf("tbl%0d_frame", k), 32'(oFRAME), 32'(tbl[ti].frm));
                ti++;
            end
        end
        check("tbl_all_used", ti, 13);

        // Brightness: driven cycles per frame of four slots.
        iBRIGHT = 4'd0;
        tick();
        drv = 0;
        for (int k = 0; k < FRAME_LEN; k++) begin
            tick();
            if (oS_COM != '1) drv++;
        end
        check("bright0_driven", drv, 4);
        iBRIGHT = 4'd3;
        tick();
        drv = 0;
        for (int k = 0; k < FRAME_LEN; k++) begin
            tick();
            if (oS_COM != '1) drv++;
        end
        check("bright3_driven", drv, 16);
        iBRIGHT = 4'd15;

        // Blink on digit 1 across six frames, with a mid-slot pattern change on digit 2.
        iBLINK = 4'b0010;
        restart();
        for (int f = 0; f < 6; f++) cnt[f] = 0;
        for (int k = 1; k <= 6 * FRAME_LEN; k++) begin
            tick();
            if (oS_COM == 4'b1101) cnt[(k - 1) / FRAME_LEN]++;
            if (oS_COM == 4'b1110 || oS_COM == 4'b0111) begin
                if (oS_ENS == 8'h00) check("blink_other_lit", 0, 1);
            end
            if (k == 20) iSEG = 32'h3F775B4F;
            if (k == 24) begin
                check("shadow_old_com", 32'(oS_COM), 32'b1011);
                check("shadow_old_ens", 32'(oS_ENS), 32'h06);
            end
            if (k == 51) begin
                check("shadow_new_com", 32'(oS_COM), 32'b1011);
                check("shadow_new_ens", 32'(oS_ENS), 32'h77);
            end
        end
        check("blink_f0", cnt[0], 6);
        check("blink_f1", cnt[1], 6);
        check("blink_f2", cnt[2], 0);
        check("blink_f3", cnt[3], 0);
        check("blink_f4", cnt[4], 6);
        check("blink_f5", cnt[5], 6);
        iBLINK = '0;

        // Asynchronous reset in the middle of digit 2's drive window.
        restart();
        for (int k = 1; k <= 21; k++) tick();
        check("prerst_com", 32'(oS_COM), 32'b1011);
        #1;
        nRST = 1'b0;
        #1;
        check("async_rst_com", 32'(oS_COM), 32'hF);
        check("async_rst_ens", 32'(oS_ENS), 32'h0);
        check("async_rst_frame", 32'(oFRAME), 32'h0);
        tick();
        tick();
        nRST = 1'b1;
        tick();
        tick();
        check("postrst_frame", 32'(oFRAME), 32'h1);
        check("postrst_dark1", 32'(oS_COM), 32'hF);
        tick();
        check("postrst_dark2", 32'(oS_COM), 32'hF);
        tick();
        check("postrst_dig0_com", 32'(oS_COM), 32'b1110);
        check("postrst_dig0_ens", 32'(oS_ENS), 32'h4F);

        // One-cycle enable drop mid-frame.
        for (int k = 0; k < 10; k++) tick();
        iEN = 1'b0;
        tick();
        check("endrop_dark_com", 32'(oS_COM), 32'hF);
        check("endrop_dark_ens", 32'(oS_ENS), 32'h0);
        iEN = 1'b1;
        tick();
        check("enrestart_idle_com", 32'(oS_COM), 32'hF);
        tick();
        check("enrestart_frame", 32'(oFRAME), 32'h1);
        tick();
        tick();
        check("enrestart_dig0", 32'(oS_COM), 32'b1110);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(15) == 0) iSEG = $urandom;
            if ($urandom_range(31) == 0) iBRIGHT = 4'($urandom_range(15));
            if ($urandom_range(63) == 0) iBLINK = N_DIG'($urandom);
            if ($urandom_range(199) == 0) iEN = 1'b0;
            else if (!iEN && $urandom_range(1) == 0) iEN = 1'b1;
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
